teller_dispatcher: RTL

Ticket issuing and teller dispatch controller for the bank queue management system. It sits between the debounced customer/teller buttons and the 5-bit display values, and hands out sequential ticket numbers. It tracks how many customers are waiting and assigns the next waiting ticket to whichever teller calls. When both tellers compete for one customer, it arbitrates between them.

---
 rtl/bank_pkg.sv | 20 ++
 rtl/ticket_counter.sv | 38 +++
 rtl/teller_dispatcher.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared types and helpers for the bank queue controller: ticket width,
// the "no ticket" value, teller state encoding and ticket wrap arithmetic.
package bank_pkg;

    localparam int TICKET_W = 5;
    localparam logic [TICKET_W-1:0] TICKET_NONE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SERVE = 2'd2
    } tel_state_e;

    // Tickets run 1..t_max; zero is reserved for "no ticket", so wrap lands on 1.
    function automatic logic [TICKET_W-1:0] wrap_inc(input logic [TICKET_W-1:0] t,
                                                     input logic [TICKET_W-1:0] t_max);
        return (t >= t_max) ? TICKET_W'(1) : t + TICKET_W'(1);
    endfunction

endpackage

// File: rtl/ticket_counter.sv
// Wrapping 1..TICKET_MAX ticket counter; advance gives how many tickets
// to step past this cycle (0, 1 or 2).
module ticket_counter
    import bank_pkg::*;
#(
    parameter int TICKET_MAX = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          advance,
    output logic [TICKET_W-1:0] value
);

    localparam logic [TICKET_W-1:0] T_MAX = TICKET_W'(TICKET_MAX);

    logic [TICKET_W-1:0] plus1;
    logic [TICKET_W-1:0] plus2;

    always_comb begin
        plus1 = wrap_inc(value, T_MAX);
        plus2 = wrap_inc(plus1, T_MAX);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= TICKET_W'(1);
        end else begin
            case (advance)
                2'd0:    value <= value;
                2'd1:    value <= plus1;
                default: value <= plus2;
            endcase
        end
    end

endmodule

// File: rtl/teller_dispatcher.sv
// Ticket issue and two-teller dispatch controller for the bank queue.
// Build option DISPATCH_RR_EN: round-robin arbitration of a contested ticket (default fixed, teller 0 wins).
module teller_dispatcher
    import bank_pkg::*;
#(
    parameter int TICKET_MAX = 31,
    parameter int MAX_WAIT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                open_en,
    input  logic                cust_req,
    input  logic [1:0]          tel_req,
    output logic [TICKET_W-1:0] cust_ticket,
    output logic                cust_ack,
    output logic                cust_rej,
    output logic [TICKET_W-1:0] waiting,
    output logic [TICKET_W-1:0] tel_ticket0,
    output logic [TICKET_W-1:0] tel_ticket1,
    output logic [1:0]          tel_wait
);

    localparam logic [TICKET_W-1:0] WAIT_LIMIT = TICKET_W'(MAX_WAIT);
    localparam logic [TICKET_W-1:0] T_MAX      = TICKET_W'(TICKET_MAX);

    tel_state_e          state_q      [2];
    logic [TICKET_W-1:0] ticket_q     [2];
    logic [TICKET_W-1:0] grant_ticket [2];

    logic [TICKET_W-1:0] issue_val;
    logic [TICKET_W-1:0] serve_val;
    logic [TICKET_W-1:0] serve_next;
    logic [TICKET_W-1:0] waiting_d;
    logic [1:0]          eligible;
    logic [1:0]          grant;
    logic [1:0]          n_disp;
    logic                issue;
    logic                has_one;
    logic                has_two;
    logic                prio;

    ticket_counter #(.TICKET_MAX(TICKET_MAX)) u_issue_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance ({1'b0, issue}),
        .value   (issue_val)
    );

    ticket_counter #(.TICKET_MAX(TICKET_MAX)) u_serve_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (n_disp),
        .value   (serve_val)
    );

    // NOTE: every always_comb output gets a default at the top so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        grant = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = (state_q[i] == WAIT) || tel_req[i];
        end

        // A full queue still accepts when a teller takes a ticket this cycle.
        issue   = cust_req && open_en && ((waiting < WAIT_LIMIT) || (|eligible));
        has_one = (waiting != '0) || issue;
        has_two = (waiting > TICKET_W'(1)) || ((waiting == TICKET_W'(1)) && issue);

        if (&eligible) begin
            if (has_two) begin
                grant = 2'b11;
            end else if (has_one) begin
                grant[prio] = 1'b1;
            end
        end else if (has_one) begin
            grant = eligible;
        end

        serve_next      = wrap_inc(serve_val, T_MAX);
        grant_ticket[0] = serve_val;
        grant_ticket[1] = grant[0] ? serve_next : serve_val;
        n_disp          = {1'b0, grant[0]} + {1'b0, grant[1]};
        waiting_d       = waiting + TICKET_W'(issue) - TICKET_W'(n_disp);
    end

`ifdef DISPATCH_RR_EN
    logic contested;
    logic prio_q;

    assign contested = (&eligible) && has_one && !has_two;
    assign prio      = prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (contested) begin
            prio_q <= ~prio_q;
        end
    end
`else
    assign prio = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            waiting     <= '0;
            cust_ticket <= TICKET_NONE;
            cust_ack    <= 1'b0;
            cust_rej    <= 1'b0;
            tel_wait    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i]  <= IDLE;
                ticket_q[i] <= TICKET_NONE;
            end
        end else begin
            waiting  <= waiting_d;
            cust_ack <= issue;
            cust_rej <= cust_req && !issue;
            if (issue) begin
                cust_ticket <= issue_val;
            end
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    state_q[i]  <= SERVE;
                    ticket_q[i] <= grant_ticket[i];
                    tel_wait[i] <= 1'b0;
                end else if (eligible[i]) begin
                    state_q[i]  <= WAIT;
                    ticket_q[i] <= TICKET_NONE;
                    tel_wait[i] <= 1'b1;
                end
            end
        end
    end

    assign tel_ticket0 = ticket_q[0];
    assign tel_ticket1 = ticket_q[1];

endmodule
